fifo_rd_streamer: RTL

//  Drain stage directly downstream of the synchronous FIFO. Issues rd_en to the FIFO and captures

---
 rtl/fifo_rd_streamer.sv | 79 +++++++
 1 files changed

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: FIFO drain stage with 2-entry skid buffer, burst framing and sticky underflow flag.
// Optional FIFO_RD_STREAMER_PARITY_EN adds m_parity = ^m_data carried alongside each skid entry.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN = 4,
  localparam int CW = $clog2(BURST_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
`ifdef FIFO_RD_STREAMER_PARITY_EN
  output logic                  m_parity,
`endif
  output logic                  m_last,
  output logic [CW-1:0]         burst_cnt,
  output logic                  underflow_err
);
  logic [1:0] occ_q, occ_d, wr_pos;
  logic inflight_q, pop, err_q, err_d;
  logic [2:0] credit;
  logic [FIFO_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef FIFO_RD_STREAMER_PARITY_EN
  logic p0_q, p0_d, p1_q, p1_d;
  assign m_parity = p0_q;
`endif
  assign m_valid = occ_q != 2'd0;
  assign m_data = e0_q;
  assign m_last = m_valid && cnt_q == CW'(BURST_LEN - 1);
  assign burst_cnt = cnt_q;
  assign underflow_err = err_q;
  // Credits count both stored words and the word already requested, so the skid never overflows.
  always_comb begin
    pop = m_valid && m_ready;
    credit = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rd_en = !rst && !fifo_empty && credit < 3'd2;
    wr_pos = occ_q - {1'b0, pop};
    e0_d = (inflight_q && wr_pos == 2'd0) ? fifo_data_out : pop ? e1_q : e0_q;
    e1_d = (inflight_q && wr_pos == 2'd1) ? fifo_data_out : e1_q;
`ifdef FIFO_RD_STREAMER_PARITY_EN
    p0_d = (inflight_q && wr_pos == 2'd0) ? ^fifo_data_out : pop ? p1_q : p0_q;
    p1_d = (inflight_q && wr_pos == 2'd1) ? ^fifo_data_out : p1_q;
`endif
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    cnt_d = pop ? (m_last ? '0 : cnt_q + CW'(1)) : cnt_q;
    err_d = err_q | fifo_underflow;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      inflight_q <= 1'b0;
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef FIFO_RD_STREAMER_PARITY_EN
      p0_q <= 1'b0;
      p1_q <= 1'b0;
`endif
    end else begin
      occ_q <= occ_d;
      inflight_q <= fifo_rd_en;
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
`ifdef FIFO_RD_STREAMER_PARITY_EN
      p0_q <= p0_d;
      p1_q <= p1_d;
`endif
    end
  end
endmodule
